uart_tx_fifo: RTL and testbench

// - Byte FIFO and launch sequencer in front of the RS232 transmitter.
// - CPU/IO-bus side pushes bytes at up to one per clk, with no handshake beyond full.
// - Drains bytes in order into the transmitter's TX / start_TX / TX_ready interface:
//   one start pulse per byte, never while the transmitter is busy.
// - Tracks dropped bytes with overflow flags.

---
 rtl/uart_pkg.sv | 5 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/uart_tx_fifo.sv | 91 +++++++++
 tb/tb_uart_tx_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and clock constant for the UART transmit queue
package uart_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE} uart_txq_state_t;
  localparam int UART_CLK_HZ = 50_000_000;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO; ports clk, rst (sync active-low), push, pop, din, dout (comb head), full, empty, count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    count_d  = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end
  assign dout  = mem_q[rd_ptr_q];
  assign full  = count_q == (ADDR_W+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue that launches one start_tx pulse per byte into an RS232 transmitter
// ports: clk, rst (sync active-low); wr_en/wr_data push side with full/empty/count;
// overflow pulse, overflow_flag (clr_overflow), launch_err; uart_tx_data/uart_start_tx/uart_tx_ready to transmitter
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ACK_WAIT = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              overflow_flag,
  input  logic              clr_overflow,
  output logic              launch_err,
  output logic [7:0]        uart_tx_data,
  output logic              uart_start_tx,
  input  logic              uart_tx_ready
);
  localparam int WAIT_W = $clog2(ACK_WAIT + 1);
  uart_txq_state_t state_q, state_d;
  logic [7:0] data_q, data_d, fifo_dout;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic start_q, start_d, ovf_q, ovf_d, flag_q, flag_d, err_q, err_d;
  logic push, pop, timeout;
  assign pop     = state_q == S_IDLE && !empty && uart_tx_ready;
  assign push    = wr_en && (!full || pop);
  assign timeout = state_q == S_WAIT_BUSY && uart_tx_ready && wait_q == WAIT_W'(ACK_WAIT - 1);
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:      state_d = pop ? S_LAUNCH : S_IDLE;
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: state_d = !uart_tx_ready ? S_WAIT_DONE : timeout ? S_IDLE : S_WAIT_BUSY;
      S_WAIT_DONE: state_d = uart_tx_ready ? S_IDLE : S_WAIT_DONE;
      default:     state_d = S_IDLE;
    endcase
  end
  // wait counter runs only in S_WAIT_BUSY, so it is zero on entry from S_LAUNCH
  always_comb begin
    data_d  = pop ? fifo_dout : data_q;
    start_d = pop;
    wait_d  = state_q == S_WAIT_BUSY ? wait_q + WAIT_W'(1) : '0;
    err_d   = err_q || timeout;
    ovf_d   = wr_en && full && !pop;
    flag_d  = ovf_d || (flag_q && !clr_overflow);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q  <= '0;
      start_q <= 1'b0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      start_q <= start_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      flag_q  <= flag_d;
    end
  end
  assign uart_tx_data  = data_q;
  assign uart_start_tx = start_q;
  assign launch_err    = err_q;
  assign overflow      = ovf_q;
  assign overflow_flag = flag_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized scoreboard bench with a transaction-level model of queue and link
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int ACK_WAIT = 8;
  logic clk = 0, rst_n = 0, wr_en = 0, clr = 0, bfm_stall = 0, bfm_deaf = 0, chk_en = 0;
  logic [7:0] wr_data = 0;
  logic full, empty, overflow, overflow_flag, launch_err, uart_start_tx, uart_tx_ready;
  logic [7:0] uart_tx_data;
  logic [4:0] count;
  int n_tests = 0, n_fail = 0, cyc = 0, bfm_cnt = 0, n_pulses = 0, last_start_cyc = -100;
  logic [7:0] m_q[$], sb[$];
  logic [7:0] m_data = 0;
  bit m_busy = 0, m_fell = 0, m_start = 0, m_ovf = 0, m_flag = 0, m_err = 0;
  bit p_pop, p_acc, p_ev, prev_start = 0, prev_ready = 0;
  int m_age = 0;

  always #10 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .ACK_WAIT(ACK_WAIT)) dut (
    .clk           (clk),
    .rst           (rst_n),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .overflow_flag (overflow_flag),
    .clr_overflow  (clr),
    .launch_err    (launch_err),
    .uart_tx_data  (uart_tx_data),
    .uart_start_tx (uart_start_tx),
    .uart_tx_ready (uart_tx_ready)
  );

  // transmitter BFM: busy for 10 clks after each start pulse
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_start_tx && !bfm_deaf) bfm_cnt <= 10;
    else if (bfm_cnt > 0) bfm_cnt <= bfm_cnt - 1;
  end
  assign uart_tx_ready = !bfm_stall && bfm_cnt == 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: queue contents plus one byte "on the link" whose life ends
  // when ready has fallen and risen again, or after the acknowledge window expires
  task automatic model_step();
    if (chk_en) begin
      chk("empty", empty, m_q.size() == 0);
      chk("full", full, m_q.size() == DEPTH);
      chk("count", count, m_q.size());
      chk("start", uart_start_tx, m_start);
      chk("tx_data", uart_tx_data, m_data);
      chk("overflow", overflow, m_ovf);
      chk("overflow_flag", overflow_flag, m_flag);
      chk("launch_err", launch_err, m_err);
    end
    if (!rst_n) begin
      m_q.delete();
      m_busy = 0; m_fell = 0; m_age = 0; m_start = 0; m_data = 0;
      m_ovf = 0; m_flag = 0; m_err = 0;
    end else begin
      p_pop = !m_busy && m_q.size() > 0 && uart_tx_ready;
      p_acc = wr_en && (m_q.size() < DEPTH || p_pop);
      p_ev  = wr_en && m_q.size() == DEPTH && !p_pop;
      if (m_busy) begin
        if (m_fell) begin
          if (uart_tx_ready) m_busy = 0;
        end else if (m_age >= 2) begin
          if (!uart_tx_ready) m_fell = 1;
          else if (m_age == ACK_WAIT + 1) begin m_err = 1; m_busy = 0; end
        end
        m_age++;
      end else if (p_pop) begin
        m_busy = 1; m_fell = 0; m_age = 1;
      end
      if (p_pop) begin
        m_data = m_q.pop_front();
        sb.push_back(m_data);
      end
      if (p_acc) m_q.push_back(wr_data);
      m_start = p_pop;
      m_ovf = p_ev;
      m_flag = p_ev || (m_flag && !clr);
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  // scoreboard monitor: every start pulse must carry the oldest launched byte
  initial forever begin
    @(negedge clk);
    if (chk_en && uart_start_tx) begin
      n_pulses++;
      last_start_cyc = cyc;
      chk("launch_ready", prev_ready, 1);
      chk("pulse_gap", prev_start, 0);
      if (sb.size() == 0) chk("sb_unexpected", 1, 0);
      else chk("sb_data", uart_tx_data, sb.pop_front());
    end
    prev_start = uart_start_tx;
    prev_ready = uart_tx_ready;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] d);
    wr_en = 1; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (!(m_q.size() == 0 && !m_busy && uart_tx_ready) && k < 3000) begin
      tick();
      k++;
    end
    chk(nm, k < 3000, 1);
  endtask

  initial begin
    int t0, p0, k;
    tick();
    chk_en = 1;
    repeat (2) tick();
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_data", uart_tx_data, 0);
    rst_n = 1;
    repeat (2) tick();
    // single byte latency
    p0 = n_pulses;
    t0 = cyc;
    push(8'hA5);
    repeat (20) tick();
    chk("t1_pulses", n_pulses - p0, 1);
    chk("t1_latency", last_start_cyc - t0, 2);
    // in-order burst
    for (int i = 0; i < 16; i++) push(8'(i));
    wait_idle("t2_drain");
    // overflow with stalled transmitter
    bfm_stall = 1;
    tick();
    for (int i = 0; i < 16; i++) push(8'($urandom));
    chk("t3_full", full, 1);
    push(8'h55);
    chk("t3_ovf_pulse", overflow, 1);
    chk("t3_ovf_flag", overflow_flag, 1);
    clr = 1; tick(); clr = 0;
    chk("t3_flag_clr", overflow_flag, 0);
    wr_en = 1; wr_data = 8'h55; clr = 1;
    tick();
    wr_en = 0; clr = 0;
    chk("t3_ovf_wins", overflow_flag, 1);
    clr = 1; tick(); clr = 0;
    // release while pushing every clk: push on pop clk is accepted
    bfm_stall = 0;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1; wr_data = 8'($urandom);
      tick();
    end
    wr_en = 0;
    wait_idle("t4_drain");
    // transmitter never acknowledges
    bfm_deaf = 1;
    push(8'h11);
    push(8'h22);
    repeat (14) tick();
    chk("t5_launch_err", launch_err, 1);
    bfm_deaf = 0;
    wait_idle("t5_drain");
    // reset mid-transfer
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
    k = 0;
    while (uart_tx_ready && k < 30) begin tick(); k++; end
    chk("t6_busy_seen", k < 30, 1);
    rst_n = 0; tick(); rst_n = 1;
    chk("t6_empty", empty, 1);
    chk("t6_count", count, 0);
    chk("t6_err_clr", launch_err, 0);
    p0 = n_pulses;
    repeat (40) tick();
    chk("t6_no_pulse", n_pulses - p0, 0);
    sb.delete();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wr_en = $urandom_range(0, 3) == 0;
      wr_data = 8'($urandom);
      clr = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 199) == 0) bfm_stall = !bfm_stall;
      if ($urandom_range(0, 499) == 0) bfm_deaf = !bfm_deaf;
      rst_n = $urandom_range(0, 999) != 0;
      tick();
    end
    wr_en = 0; clr = 0; bfm_stall = 0; bfm_deaf = 0; rst_n = 1;
    wait_idle("rand_drain");
    repeat (3) tick();
    chk("sb_left", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
